// File: rtl/byte_mem_pkg.sv
// byte_mem_pkg: shared widths, requester encoding and read tag for the byte memory arbiter
package byte_mem_pkg;
    localparam int AW = 17;
    localparam int DW = 8;
    localparam int WB_DEPTH = 2;

    typedef enum logic [1:0] {REQ_NONE, REQ_WR, REQ_RS, REQ_TS} req_e;

    typedef struct packed {
        logic rs;
        logic ts;
    } rd_tag_t;
endpackage

// File: rtl/byte_mem_arb_if.sv
// byte_mem_arb_if: requester and memory-macro signals around the byte memory arbiter
interface byte_mem_arb_if;
    import byte_mem_pkg::*;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rs_req;
    logic          rs_we;
    logic [AW-1:0] rs_addr;
    logic [DW-1:0] rs_wdata;
    logic          rs_gnt;
    logic          rs_rvalid;
    logic [DW-1:0] rs_rdata;
    logic          ts_req;
    logic [AW-1:0] ts_addr;
    logic          ts_gnt;
    logic          ts_rvalid;
    logic [DW-1:0] ts_rdata;
    logic          wb_empty;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_do;

    modport master (
        output wr_req, wr_addr, wr_data, rs_req, rs_we, rs_addr, rs_wdata, ts_req, ts_addr, mem_do,
        input  rs_gnt, rs_rvalid, rs_rdata, ts_gnt, ts_rvalid, ts_rdata, wb_empty,
               mem_en, mem_wr, mem_addr, mem_di
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rs_req, rs_we, rs_addr, rs_wdata, ts_req, ts_addr, mem_do,
        output rs_gnt, rs_rvalid, rs_rdata, ts_gnt, ts_rvalid, ts_rdata, wb_empty,
               mem_en, mem_wr, mem_addr, mem_di
    );
endinterface

// File: rtl/byte_wbuf.sv
// byte_wbuf: 2-entry shift FIFO absorbing the unstallable byte writer
module byte_wbuf
    import byte_mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [AW+DW-1:0] din,
    output logic [AW+DW-1:0] dout,
    output logic [1:0]       count,
    output logic             empty
);
    logic [AW+DW-1:0] tail;
    logic [1:0]       count_nxt;

    assign count_nxt = count + {1'b0, push} - {1'b0, pop};

    // head entry is dout; unused slots may take din freely since count marks validity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout  <= '0;
            tail  <= '0;
            count <= '0;
            empty <= 1'b1;
        end else begin
            dout  <= pop ? (count == 2'(WB_DEPTH) ? tail : din) : (count == 2'd0 ? din : dout);
            tail  <= push ? din : tail;
            count <= count_nxt;
            empty <= count_nxt == 2'd0;
        end
    end
endmodule

// File: rtl/byte_mem_arb.sv
// byte_mem_arb: one access per cycle to the shared byte memory, with tagged read return
module byte_mem_arb
    import byte_mem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    byte_mem_arb_if.slave bus
);
    req_e             sel;
    req_e             rr_ptr;
    rd_tag_t          tag1;
    rd_tag_t          tag2;
    logic [1:0]       wb_count;
    logic [AW+DW-1:0] wb_head;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;

    assign {wb_addr, wb_data} = wb_head;

    byte_wbuf u_wbuf (
        .clk   (clk),
        .reset (reset),
        .push  (bus.wr_req),
        .pop   (sel == REQ_WR),
        .din   ({bus.wr_addr, bus.wr_data}),
        .dout  (wb_head),
        .count (wb_count),
        .empty (bus.wb_empty)
    );

    // full buffer wins, then RS/TS round-robin, then drain a lone buffered byte
    always_comb
        sel = wb_count == 2'(WB_DEPTH) ? REQ_WR :
              bus.rs_req && bus.ts_req ? rr_ptr :
              bus.rs_req ? REQ_RS :
              bus.ts_req ? REQ_TS :
              wb_count == 2'd1 ? REQ_WR : REQ_NONE;

    assign bus.rs_gnt = !reset && sel == REQ_RS;
    assign bus.ts_gnt = !reset && sel == REQ_TS;

    // present the granted access on the memory port in the cycle after the grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_en   <= 1'b0;
            bus.mem_wr   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_di   <= '0;
        end else begin
            bus.mem_en   <= sel != REQ_NONE;
            bus.mem_wr   <= sel == REQ_WR || (sel == REQ_RS && bus.rs_we);
            bus.mem_addr <= sel == REQ_WR ? wb_addr :
                            sel == REQ_RS ? bus.rs_addr :
                            sel == REQ_TS ? bus.ts_addr : bus.mem_addr;
            bus.mem_di   <= sel == REQ_WR ? wb_data :
                            sel == REQ_RS && bus.rs_we ? bus.rs_wdata : bus.mem_di;
        end
    end

    // pointer names the requester that wins the next RS/TS tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= REQ_RS;
        else
            rr_ptr <= sel == REQ_RS ? REQ_TS : sel == REQ_TS ? REQ_RS : rr_ptr;
    end

    // tags ride alongside each read so the returned byte reaches its requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag1          <= '0;
            tag2          <= '0;
            bus.rs_rvalid <= 1'b0;
            bus.ts_rvalid <= 1'b0;
            bus.rs_rdata  <= '0;
            bus.ts_rdata  <= '0;
        end else begin
            tag1          <= '{rs: sel == REQ_RS && !bus.rs_we, ts: sel == REQ_TS};
            tag2          <= tag1;
            bus.rs_rvalid <= tag2.rs;
            bus.ts_rvalid <= tag2.ts;
            bus.rs_rdata  <= tag2.rs ? bus.mem_do : bus.rs_rdata;
            bus.ts_rdata  <= tag2.ts ? bus.mem_do : bus.ts_rdata;
        end
    end
endmodule

// File: tb/tb_byte_mem_arb.sv
// tb_byte_mem_arb: randomized and directed checks of byte_mem_arb against a queue-based model
module tb_byte_mem_arb;
    import byte_mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    byte_mem_arb_if bus();
    byte_mem_arb dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    // memory macro: 1-cycle synchronous read
    always @(posedge clk)
        if (bus.mem_en) begin
            if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_di;
            else bus.mem_do <= mem[bus.mem_addr];
        end

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { int due; bit rs; logic [DW-1:0] d; } rd_t;
    wr_t wq[$];
    rd_t rq[$];
    bit prio_rs = 1'b1;
    logic e_en, e_wr, e_rsv, e_tsv, e_empty;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_di, e_rsd, e_tsd;

    function automatic int pick();
        if (wq.size() == 2) return 1;
        if (bus.rs_req && bus.ts_req) return prio_rs ? 2 : 3;
        if (bus.rs_req) return 2;
        if (bus.ts_req) return 3;
        if (wq.size() == 1) return 1;
        return 0;
    endfunction

    // reference model: writer queue, shadow memory applied in grant order, timed read returns
    always @(posedge clk or posedge reset) begin : model
        int s;
        wr_t w;
        rd_t r;
        if (reset) begin
            wq.delete();
            rq.delete();
            prio_rs = 1'b1;
            {e_en, e_wr, e_rsv, e_tsv} = '0;
            e_empty = 1'b1;
            e_addr = '0;
            e_di = '0;
            e_rsd = '0;
            e_tsd = '0;
        end else begin
            s = pick();
            e_en = s != 0;
            e_wr = 1'b0;
            if (s == 1) begin
                w = wq.pop_front();
                shadow[w.a] = w.d;
                e_wr = 1'b1;
                e_addr = w.a;
                e_di = w.d;
            end else if (s == 2) begin
                prio_rs = 1'b0;
                e_addr = bus.rs_addr;
                if (bus.rs_we) begin
                    shadow[bus.rs_addr] = bus.rs_wdata;
                    e_wr = 1'b1;
                    e_di = bus.rs_wdata;
                end else begin
                    r.due = cyc + 3; r.rs = 1'b1; r.d = shadow[bus.rs_addr];
                    rq.push_back(r);
                end
            end else if (s == 3) begin
                prio_rs = 1'b1;
                e_addr = bus.ts_addr;
                r.due = cyc + 3; r.rs = 1'b0; r.d = shadow[bus.ts_addr];
                rq.push_back(r);
            end
            if (bus.wr_req) begin
                w.a = bus.wr_addr; w.d = bus.wr_data;
                wq.push_back(w);
            end
            e_empty = wq.size() == 0;
            cyc++;
            e_rsv = 1'b0;
            e_tsv = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                if (r.rs) begin e_rsv = 1'b1; e_rsd = r.d; end
                else begin e_tsv = 1'b1; e_tsd = r.d; end
            end
        end
    end

    task automatic clear_inputs();
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rs_req = 0; bus.rs_we = 0; bus.rs_addr = '0; bus.rs_wdata = '0;
        bus.ts_req = 0; bus.ts_addr = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.rs_gnt, bus.ts_gnt, bus.rs_rvalid, bus.ts_rvalid, bus.rs_rdata, bus.ts_rdata,
             bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_di} !== 47'd0) begin
            errors++; $display("FAIL reset_outs got nonzero mem_en=%b mem_addr=%h", bus.mem_en, bus.mem_addr);
        end
        checks++;
        if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL reset_wb_empty got %b want 1", bus.wb_empty); end
        reset = 1'b0;
    endtask

    task automatic test_rs_read();
        bus.rs_req = 1; bus.rs_we = 0; bus.rs_addr = 17'h01B0;
        #1 checks++;
        if ({bus.rs_gnt, bus.ts_gnt} !== 2'b10) begin errors++; $display("FAIL rs_read_gnt got %b want 10", {bus.rs_gnt, bus.ts_gnt}); end
        @(negedge clk);
        bus.rs_req = 0;
        checks++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr} !== {1'b1, 1'b0, 17'h01B0}) begin
            errors++; $display("FAIL rs_read_mem got en=%b wr=%b addr=%h want 1 0 01b0", bus.mem_en, bus.mem_wr, bus.mem_addr);
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.rs_rvalid, bus.ts_rvalid} !== {k == 3, 1'b0}) begin
                errors++; $display("FAIL rs_read_rvalid n+%0d got %b%b want %b0", k, bus.rs_rvalid, bus.ts_rvalid, k == 3);
            end
            if (k >= 3) begin
                checks++;
                if (bus.rs_rdata !== 8'h5A) begin errors++; $display("FAIL rs_read_rdata n+%0d got %h want 5a", k, bus.rs_rdata); end
            end
        end
    endtask

    task automatic test_rr();
        int nrv = 0;
        int g;
        bit rg = 1, tg = 1;
        bus.rs_we = 0;
        for (int i = 0; i < 10; i++) begin
            bus.rs_req = i < 6;
            bus.ts_req = i < 6;
            if (rg) bus.rs_addr = AW'($urandom_range(0, (1 << AW) - 1));
            if (tg) bus.ts_addr = AW'($urandom_range(0, (1 << AW) - 1));
            #1 g = pick();
            rg = g == 2; tg = g == 3;
            checks++;
            if ({bus.rs_gnt, bus.ts_gnt} !== {g == 2, g == 3}) begin
                errors++; $display("FAIL rr_gnt cycle %0d got %b%b want %b%b", i, bus.rs_gnt, bus.ts_gnt, g == 2, g == 3);
            end
            @(negedge clk);
            checks++;
            if ({bus.rs_rvalid, bus.ts_rvalid, bus.rs_rdata, bus.ts_rdata} !== {e_rsv, e_tsv, e_rsd, e_tsd}) begin
                errors++; $display("FAIL rr_rdata cycle %0d got %b%b %h %h want %b%b %h %h", i, bus.rs_rvalid, bus.ts_rvalid,
                                   bus.rs_rdata, bus.ts_rdata, e_rsv, e_tsv, e_rsd, e_tsd);
            end
            nrv += int'(bus.rs_rvalid) + int'(bus.ts_rvalid);
        end
        checks++;
        if (nrv != 6) begin errors++; $display("FAIL rr_count got %0d want 6", nrv); end
    endtask

    task automatic test_writer();
        int nw = 0, nrs = 0, g;
        bit rg = 1;
        for (int i = 0; i < 14; i++) begin
            bus.wr_req = i < 3;
            bus.wr_addr = AW'(i);
            bus.wr_data = DW'(8'h10 + i);
            bus.rs_req = i < 8;
            bus.rs_we = 0;
            if (rg) bus.rs_addr = AW'($urandom_range(256, 511));
            #1 g = pick();
            rg = g == 2;
            checks++;
            if ({bus.rs_gnt, bus.ts_gnt} !== {g == 2, 1'b0}) begin
                errors++; $display("FAIL writer_gnt cycle %0d got %b%b want %b0", i, bus.rs_gnt, bus.ts_gnt, g == 2);
            end
            if (bus.rs_gnt && !bus.wb_empty) nrs++;
            @(negedge clk);
            checks++;
            if ({bus.mem_en, bus.mem_wr} !== {e_en, e_wr}) begin
                errors++; $display("FAIL writer_mem cycle %0d got en=%b wr=%b want %b %b", i, bus.mem_en, bus.mem_wr, e_en, e_wr);
            end
            if (bus.mem_en && bus.mem_wr) begin
                checks++;
                if ({bus.mem_addr, bus.mem_di} !== {AW'(nw), DW'(8'h10 + nw)}) begin
                    errors++; $display("FAIL writer_order write %0d got %h/%h want %h/%h", nw, bus.mem_addr, bus.mem_di, nw, 8'h10 + nw);
                end
                nw++;
            end
            checks++;
            if (bus.wb_empty !== e_empty) begin errors++; $display("FAIL writer_empty cycle %0d got %b want %b", i, bus.wb_empty, e_empty); end
        end
        checks++;
        if (nw != 3) begin errors++; $display("FAIL writer_count got %0d want 3", nw); end
        checks++;
        if (nrs == 0) begin errors++; $display("FAIL writer_rs_between got %0d want >0", nrs); end
        checks++;
        if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL writer_final_empty got %b want 1", bus.wb_empty); end
    endtask

    task automatic test_wr_single();
        bus.wr_req = 1; bus.wr_addr = 17'h01AF; bus.wr_data = 8'hC3;
        @(negedge clk);
        bus.wr_req = 0;
        checks++;
        if ({bus.mem_en, bus.wb_empty} !== 2'b00) begin
            errors++; $display("FAIL wr_single_n1 got en=%b empty=%b want 0 0", bus.mem_en, bus.wb_empty);
        end
        @(negedge clk);
        checks++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_di} !== {1'b1, 1'b1, 17'h01AF, 8'hC3}) begin
            errors++; $display("FAIL wr_single_mem got %b %b %h %h want 1 1 01af c3", bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_di);
        end
        checks++;
        if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL wr_single_empty got %b want 1", bus.wb_empty); end
    endtask

    task automatic test_idle();
        clear_inputs();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.mem_en, bus.rs_rvalid, bus.ts_rvalid} !== 3'b000) begin
                errors++; $display("FAIL idle cycle %0d got en=%b rv=%b%b want 000", i, bus.mem_en, bus.rs_rvalid, bus.ts_rvalid);
            end
        end
    endtask

    task automatic test_random();
        int g;
        bit rg = 1, tg = 1, live;
        for (int i = 0; i < 400; i++) begin
            live = i < 390;
            if (rg) begin
                bus.rs_req = live && $urandom_range(0, 2) == 0;
                bus.rs_we = 1'($urandom_range(0, 1));
                bus.rs_addr = AW'($urandom_range(0, 31));
                bus.rs_wdata = DW'($urandom);
            end
            if (tg) begin
                bus.ts_req = live && $urandom_range(0, 2) == 0;
                bus.ts_addr = AW'($urandom_range(0, 31));
            end
            bus.wr_req = live && $urandom_range(0, 3) == 0;
            bus.wr_addr = AW'($urandom_range(0, 31));
            bus.wr_data = DW'($urandom);
            #1 g = pick();
            rg = !bus.rs_req || g == 2;
            tg = !bus.ts_req || g == 3;
            checks++;
            if ({bus.rs_gnt, bus.ts_gnt} !== {g == 2, g == 3}) begin
                errors++; $display("FAIL rand_gnt cycle %0d got %b%b want %b%b", i, bus.rs_gnt, bus.ts_gnt, g == 2, g == 3);
            end
            @(negedge clk);
            checks++;
            if ({bus.mem_en, bus.mem_wr} !== {e_en, e_wr}) begin
                errors++; $display("FAIL rand_mem cycle %0d got en=%b wr=%b want %b %b", i, bus.mem_en, bus.mem_wr, e_en, e_wr);
            end
            if (e_en) begin
                checks++;
                if (bus.mem_addr !== e_addr) begin errors++; $display("FAIL rand_addr cycle %0d got %h want %h", i, bus.mem_addr, e_addr); end
            end
            if (e_wr) begin
                checks++;
                if (bus.mem_di !== e_di) begin errors++; $display("FAIL rand_di cycle %0d got %h want %h", i, bus.mem_di, e_di); end
            end
            checks++;
            if ({bus.rs_rvalid, bus.ts_rvalid, bus.rs_rdata, bus.ts_rdata} !== {e_rsv, e_tsv, e_rsd, e_tsd}) begin
                errors++; $display("FAIL rand_rdata cycle %0d got %b%b %h %h want %b%b %h %h", i, bus.rs_rvalid, bus.ts_rvalid,
                                   bus.rs_rdata, bus.ts_rdata, e_rsv, e_tsv, e_rsd, e_tsd);
            end
            checks++;
            if (bus.wb_empty !== e_empty) begin errors++; $display("FAIL rand_empty cycle %0d got %b want %b", i, bus.wb_empty, e_empty); end
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        bus.ts_req = 1; bus.ts_addr = 17'h0123;
        #1 checks++;
        if ({bus.rs_gnt, bus.ts_gnt} !== 2'b01) begin errors++; $display("FAIL rmid_ts_gnt got %b want 01", {bus.rs_gnt, bus.ts_gnt}); end
        @(negedge clk);
        reset = 1'b1;
        bus.rs_req = 1; bus.rs_addr = 17'h0055;
        for (int k = 0; k < 2; k++) begin
            #1 checks++;
            if ({bus.rs_gnt, bus.ts_gnt, bus.rs_rvalid, bus.ts_rvalid, bus.rs_rdata, bus.ts_rdata,
                 bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_di, ~bus.wb_empty} !== 48'd0) begin
                errors++; $display("FAIL rmid_outs %0d got gnt=%b%b en=%b empty=%b want all 0, empty 1", k,
                                   bus.rs_gnt, bus.ts_gnt, bus.mem_en, bus.wb_empty);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1 checks++;
        if ({bus.rs_gnt, bus.ts_gnt} !== 2'b10) begin errors++; $display("FAIL rmid_first_gnt got %b want 10", {bus.rs_gnt, bus.ts_gnt}); end
        @(negedge clk);
        clear_inputs();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({bus.rs_rvalid, bus.ts_rvalid} !== {k == 2, 1'b0}) begin
                errors++; $display("FAIL rmid_rvalid %0d got %b%b want %b0", k, bus.rs_rvalid, bus.ts_rvalid, k == 2);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clear_inputs();
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = DW'(i * 7 + 3);
            shadow[i] = mem[i];
        end
        mem[17'h01B0] = 8'h5A;
        shadow[17'h01B0] = 8'h5A;
        test_reset();
        test_rs_read();
        test_rr();
        test_writer();
        test_wr_single();
        test_idle();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
